// File: rtl/prbs_pkg.sv
// PRBS checker shared definitions: state enum, generator geometry
// and the XNOR feedback prediction used by the checker.
package prbs_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int PRBS_WIDTH = 8;
    localparam int TAP_HI     = 7;
    localparam int TAP_LO     = 3;

    localparam logic [PRBS_WIDTH-1:0] LOCKUP = 8'hFF;

    localparam int LOCK_CNT_DEF  = 8;
    localparam int LOSS_ERRS_DEF = 4;
    localparam int WINDOW_DEF    = 64;

    function automatic logic prbs_predict(
        input logic [PRBS_WIDTH-1:0] sr
    );
        return ~(sr[TAP_HI] ^ sr[TAP_LO]);
    endfunction

endpackage

// File: rtl/prbs_err_window.sv
// Error tally over a window of valid bits opened by the first error;
// loss fires combinationally on the error that completes the tally.
module prbs_err_window
    import prbs_pkg::*;
#(
    parameter int LOSS_ERRS = LOSS_ERRS_DEF,
    parameter int WINDOW    = WINDOW_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic valid,
    input  logic err,
    input  logic clr,
    output logic loss
);

    localparam int CW = $clog2(WINDOW + 1);
    localparam int TW = $clog2(LOSS_ERRS + 1);

    logic          active;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tally;
    logic          open_win;
    logic          hit;

    // window is open until it has spanned WINDOW valid bits
    always_comb begin
        open_win = active && (cnt != CW'(WINDOW));
        hit      = valid && err;
        loss     = 1'b0;
        if (hit) begin
            if (open_win)
                loss = (tally == TW'(LOSS_ERRS - 1));
            else
                loss = (LOSS_ERRS == 1);
        end
    end

    // track window position and error tally; an expired window restarts
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            active <= 1'b0;
            cnt    <= '0;
            tally  <= '0;
        end else if (valid) begin
            if (open_win) begin
                cnt <= cnt + CW'(1);
                if (err)
                    tally <= tally + TW'(1);
            end else if (err) begin
                active <= 1'b1;
                cnt    <= CW'(1);
                tally  <= TW'(1);
            end else begin
                active <= 1'b0;
                cnt    <= '0;
                tally  <= '0;
            end
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// PRBS-8 XNOR (taps 7,3) checker with hunt/lock FSM and error stats.
// Optional PRBS_CHECKER_BITCNT_EN adds a locked valid-bit counter.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_CNT  = LOCK_CNT_DEF,
    parameter int LOSS_ERRS = LOSS_ERRS_DEF,
    parameter int WINDOW    = WINDOW_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_bit,
    input  logic        in_valid,
    input  logic        clear_cnt,
`ifdef PRBS_CHECKER_BITCNT_EN
    output logic [31:0] bit_count,
`endif
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count
);

    localparam int FW = $clog2(PRBS_WIDTH + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);

    state_t                state;
    logic [PRBS_WIDTH-1:0] sr;
    logic [FW-1:0]         fill;
    logic [MW-1:0]         match_cnt;
    logic                  pred;
    logic                  mis;
    logic                  is_lk;
    logic                  lk_err;
    logic                  loss;

    // prediction and locked-mode error detection
    always_comb begin
        pred   = prbs_predict(sr);
        mis    = (in_bit != pred);
        is_lk  = (state == LOCKED);
        lk_err = in_valid && is_lk && mis;
    end

    prbs_err_window #(
        .LOSS_ERRS(LOSS_ERRS),
        .WINDOW   (WINDOW)
    ) u_win (
        .clk  (clk),
        .reset(reset),
        .valid(in_valid && is_lk),
        .err  (mis),
        .clr  (!is_lk),
        .loss (loss)
    );

    // hunt/lock FSM; flywheel on predictions once locked
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HUNT;
            sr        <= '0;
            fill      <= '0;
            match_cnt <= '0;
            locked    <= 1'b0;
        end else if (in_valid) begin
            unique case (state)
                HUNT: begin
                    sr <= {sr[PRBS_WIDTH-2:0], in_bit};
                    if (fill != FW'(PRBS_WIDTH))
                        fill <= fill + FW'(1);
                    if (fill == FW'(PRBS_WIDTH)) begin
                        if (!mis && sr != LOCKUP) begin
                            if (match_cnt == MW'(LOCK_CNT - 1)) begin
                                state     <= LOCKED;
                                locked    <= 1'b1;
                                match_cnt <= '0;
                            end else begin
                                match_cnt <= match_cnt + MW'(1);
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                end
                LOCKED: begin
                    sr <= {sr[PRBS_WIDTH-2:0], pred};
                    if (loss) begin
                        state     <= HUNT;
                        locked    <= 1'b0;
                        fill      <= '0;
                        match_cnt <= '0;
                    end
                end
                default: begin
                    state  <= HUNT;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    // error pulse and saturating error count; clear before count
    always_ff @(posedge clk) begin
        if (reset) begin
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= lk_err;
            if (clear_cnt)
                err_count <= {15'd0, lk_err};
            else if (lk_err && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
        end
    end

`ifdef PRBS_CHECKER_BITCNT_EN
    // saturating count of valid bits seen while locked
    always_ff @(posedge clk) begin
        if (reset || clear_cnt)
            bit_count <= '0;
        else if (in_valid && is_lk && bit_count != 32'hFFFF_FFFF)
            bit_count <= bit_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Scenario bench for prbs_checker: per-cycle expectations are queued
// as stimulus is driven and popped once the DUT has clocked it.
module tb_prbs_checker;

    logic        clk;
    logic        reset;
    logic        in_bit;
    logic        in_valid;
    logic        clear_cnt;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
`ifdef PRBS_CHECKER_BITCNT_EN
    logic [31:0] bit_count;
`endif

    typedef struct packed {
        logic        lk;
        logic        pl;
        logic [15:0] ec;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0] gsr;

    prbs_checker dut (
        .clk      (clk),
        .reset    (reset),
        .in_bit   (in_bit),
        .in_valid (in_valid),
        .clear_cnt(clear_cnt),
`ifdef PRBS_CHECKER_BITCNT_EN
        .bit_count(bit_count),
`endif
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // golden XNOR generator, taps 7,3, LSB inserted
    task automatic gen(output logic b);
        b   = ~(gsr[7] ^ gsr[3]);
        gsr = {gsr[6:0], b};
    endtask

    task automatic step(
        input logic        r,
        input logic        v,
        input logic        b,
        input logic        c,
        input logic        elk,
        input logic        epl,
        input logic [15:0] eec
    );
        exp_t e;
        exp_t got;
        reset     = r;
        in_valid  = v;
        in_bit    = b;
        clear_cnt = c;
        e.lk = elk;
        e.pl = epl;
        e.ec = eec;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        n_cmp++;
        if (locked !== got.lk) begin
            n_bad++;
            $display("FAIL locked t=%0t got=%b exp=%b",
                     $time, locked, got.lk);
        end
        n_cmp++;
        if (err_pulse !== got.pl) begin
            n_bad++;
            $display("FAIL err_pulse t=%0t got=%b exp=%b",
                     $time, err_pulse, got.pl);
        end
        n_cmp++;
        if (err_count !== got.ec) begin
            n_bad++;
            $display("FAIL err_count t=%0t got=%0d exp=%0d",
                     $time, err_count, got.ec);
        end
    endtask

    task automatic reset_dut();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        gsr = 8'h00;
    endtask

    task automatic do_lock();
        logic b;
        reset_dut();
        for (int i = 1; i <= 16; i++) begin
            gen(b);
            step(1'b0, 1'b1, b, 1'b0, (i == 16), 1'b0, 16'd0);
        end
    endtask

    task automatic test_reset();
        reset_dut();
    endtask

    task automatic test_golden();
        logic b;
        reset_dut();
        for (int i = 1; i <= 40; i++) begin
            gen(b);
            step(1'b0, 1'b1, b, 1'b0, (i >= 16), 1'b0, 16'd0);
        end
`ifdef PRBS_CHECKER_BITCNT_EN
        n_cmp++;
        if (bit_count !== 32'd24) begin
            n_bad++;
            $display("FAIL bit_count got=%0d exp=24", bit_count);
        end
`endif
    endtask

    task automatic test_alt_valid();
        logic b;
        int   nv;
        reset_dut();
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin
                gen(b);
                nv++;
                step(1'b0, 1'b1, b, 1'b0, (nv >= 16), 1'b0, 16'd0);
            end else begin
                step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0,
                     (nv >= 16), 1'b0, 16'd0);
            end
        end
    endtask

    task automatic test_single_err();
        logic b;
        do_lock();
        for (int i = 0; i < 5; i++) begin
            gen(b);
            step(1'b0, 1'b1, b, 1'b0, 1'b1, 1'b0, 16'd0);
        end
        gen(b);
        step(1'b0, 1'b1, ~b, 1'b0, 1'b1, 1'b1, 16'd1);
        step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0,
             1'b1, 1'b0, 16'd1);
        for (int i = 0; i < 100; i++) begin
            gen(b);
            step(1'b0, 1'b1, b, 1'b0, 1'b1, 1'b0, 16'd1);
        end
    endtask

    task automatic test_loss();
        logic        b;
        logic        f;
        logic [15:0] ec;
        do_lock();
        ec = 16'd0;
        for (int k = 1; k <= 40; k++) begin
            gen(b);
            f = (k == 2) || (k == 7) || (k == 12) || (k == 17);
            if (f)
                ec++;
            step(1'b0, 1'b1, b ^ f, 1'b0,
                 (k < 17) || (k >= 33), f, ec);
        end
    endtask

    task automatic test_window();
        logic        b;
        logic        f;
        logic [15:0] ec;
        do_lock();
        ec = 16'd0;
        for (int k = 1; k <= 70; k++) begin
            gen(b);
            f = (k <= 3) || (k >= 65 && k <= 68);
            if (f)
                ec++;
            step(1'b0, 1'b1, b ^ f, 1'b0, (k < 68), f, ec);
        end
    endtask

    task automatic test_all_ones();
        reset_dut();
        for (int i = 0; i < 200; i++)
            step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    endtask

    task automatic test_clear();
        logic b;
        do_lock();
        gen(b);
        step(1'b0, 1'b1, ~b, 1'b0, 1'b1, 1'b1, 16'd1);
        gen(b);
        step(1'b0, 1'b1, b, 1'b1, 1'b1, 1'b0, 16'd0);
        gen(b);
        step(1'b0, 1'b1, ~b, 1'b0, 1'b1, 1'b1, 16'd1);
        gen(b);
        step(1'b0, 1'b1, ~b, 1'b1, 1'b1, 1'b1, 16'd1);
    endtask

    task automatic test_reset_mid();
        logic b;
        do_lock();
        gen(b);
        step(1'b0, 1'b1, ~b, 1'b0, 1'b1, 1'b1, 16'd1);
        gen(b);
        step(1'b1, 1'b1, ~b, 1'b0, 1'b0, 1'b0, 16'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        clear_cnt = 1'b0;
        gsr       = 8'h00;
        test_reset();
        test_golden();
        test_alt_valid();
        test_single_err();
        test_loss();
        test_window();
        test_all_ones();
        test_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
